// File: rtl/scr1_imem_arb.sv
// scr1_imem_arb: shares one IMEM port between the core IFU (m0) and a secondary fetcher (m1).
// Responses are routed back in order through an ID FIFO. Define SCR1_IMEM_ARB_RR_EN for round-robin grant.

module scr1_imem_arb #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTST_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m0_imem_req,
  input  logic [ADDR_W-1:0]            m0_imem_addr,
  output logic                         m0_imem_req_ack,
  output logic [DATA_W-1:0]            m0_imem_rdata,
  output logic [1:0]                   m0_imem_resp,
  input  logic                         m1_imem_req,
  input  logic [ADDR_W-1:0]            m1_imem_addr,
  output logic                         m1_imem_req_ack,
  output logic [DATA_W-1:0]            m1_imem_rdata,
  output logic [1:0]                   m1_imem_resp,
  output logic                         s_imem_req,
  output logic [ADDR_W-1:0]            s_imem_addr,
  input  logic                         s_imem_req_ack,
  input  logic [DATA_W-1:0]            s_imem_rdata,
  input  logic [1:0]                   s_imem_resp,
  output logic [$clog2(OUTST_DEPTH):0] arb_outst_cnt,
  output logic                         arb_err
);

  localparam int CNT_W = $clog2(OUTST_DEPTH) + 1;
  localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTST_DEPTH);

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  lock_state_t      lock_state_reg;
  logic             lock_id_reg;
  logic             grant_id;
  logic [1:0]       req_vec;
  logic [ADDR_W-1:0] addr_vec [2];

  logic             fifo_mem_reg [OUTST_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             err_reg;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             resp_vld;
  logic             head_id;
  logic [1:0]       ack_vec;
  logic [1:0]       resp_vec [2];

`ifdef SCR1_IMEM_ARB_RR_EN
  logic             rr_ptr_reg;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(OUTST_DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  assign req_vec     = {m1_imem_req, m0_imem_req};
  assign addr_vec[0] = m0_imem_addr;
  assign addr_vec[1] = m1_imem_addr;

  // A stalled request owns the port until the router takes it or the requester withdraws
  always_comb begin
    grant_id = 1'b0;
    if (lock_state_reg == LOCK_HELD) begin
      grant_id = lock_id_reg;
    end else begin
`ifdef SCR1_IMEM_ARB_RR_EN
      if (&req_vec) begin
        grant_id = rr_ptr_reg;
      end else begin
        grant_id = ~m0_imem_req;
      end
`else
      grant_id = ~m0_imem_req;
`endif
    end
  end

  assign fifo_full   = (cnt_reg == CNT_FULL);
  assign fifo_empty  = (cnt_reg == '0);
  assign s_imem_req  = req_vec[grant_id] & ~fifo_full;
  assign s_imem_addr = addr_vec[grant_id];
  assign push        = s_imem_req & s_imem_req_ack;
  assign resp_vld    = |s_imem_resp;
  assign pop         = resp_vld & ~fifo_empty;
  assign head_id     = fifo_mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      localparam logic REQ_ID = (gi == 1);
      assign ack_vec[gi]  = push & (grant_id == REQ_ID);
      assign resp_vec[gi] = (pop && (head_id == REQ_ID)) ? s_imem_resp : 2'b00;
    end
  endgenerate

  assign m0_imem_req_ack = ack_vec[0];
  assign m1_imem_req_ack = ack_vec[1];
  assign m0_imem_resp    = resp_vec[0];
  assign m1_imem_resp    = resp_vec[1];
  assign m0_imem_rdata   = s_imem_rdata;
  assign m1_imem_rdata   = s_imem_rdata;

  always_comb begin
    cnt_next = cnt_reg;
    if (push && !pop) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end else if (!push && pop) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) begin
        fifo_mem_reg[wr_ptr_reg] <= grant_id;
        wr_ptr_reg               <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      cnt_reg <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_state_reg <= LOCK_IDLE;
      lock_id_reg    <= 1'b0;
    end else begin
      case (lock_state_reg)
        LOCK_IDLE: begin
          if (s_imem_req && !s_imem_req_ack) begin
            lock_state_reg <= LOCK_HELD;
            lock_id_reg    <= grant_id;
          end
        end
        LOCK_HELD: begin
          if (!req_vec[lock_id_reg] || s_imem_req_ack) begin
            lock_state_reg <= LOCK_IDLE;
          end
        end
        default: lock_state_reg <= LOCK_IDLE;
      endcase
    end
  end

  // Orphan responses and the reserved 11 code are both latched until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if ((resp_vld && fifo_empty) || (s_imem_resp == 2'b11)) begin
      err_reg <= 1'b1;
    end
  end

`ifdef SCR1_IMEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg <= 1'b0;
    end else if (push) begin
      rr_ptr_reg <= ~grant_id;
    end
  end
`endif

  assign arb_outst_cnt = cnt_reg;
  assign arb_err       = err_reg;

endmodule

// File: tb/tb_scr1_imem_arb.sv
// Self-checking bench for scr1_imem_arb: directed scenarios with literal expectations, then
// randomized traffic checked each cycle against a queue-based reference model.

module tb_scr1_imem_arb;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_imem_req, m1_imem_req;
  logic [AW-1:0] m0_imem_addr, m1_imem_addr;
  logic          m0_imem_req_ack, m1_imem_req_ack;
  logic [DW-1:0] m0_imem_rdata, m1_imem_rdata;
  logic [1:0]    m0_imem_resp, m1_imem_resp;
  logic          s_imem_req;
  logic [AW-1:0] s_imem_addr;
  logic          s_imem_req_ack;
  logic [DW-1:0] s_imem_rdata;
  logic [1:0]    s_imem_resp;
  logic [CW-1:0] arb_outst_cnt;
  logic          arb_err;

  always #5 clk = ~clk;

  scr1_imem_arb #(.ADDR_W(AW), .DATA_W(DW), .OUTST_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .m0_imem_req     (m0_imem_req),
    .m0_imem_addr    (m0_imem_addr),
    .m0_imem_req_ack (m0_imem_req_ack),
    .m0_imem_rdata   (m0_imem_rdata),
    .m0_imem_resp    (m0_imem_resp),
    .m1_imem_req     (m1_imem_req),
    .m1_imem_addr    (m1_imem_addr),
    .m1_imem_req_ack (m1_imem_req_ack),
    .m1_imem_rdata   (m1_imem_rdata),
    .m1_imem_resp    (m1_imem_resp),
    .s_imem_req      (s_imem_req),
    .s_imem_addr     (s_imem_addr),
    .s_imem_req_ack  (s_imem_req_ack),
    .s_imem_rdata    (s_imem_rdata),
    .s_imem_resp     (s_imem_resp),
    .arb_outst_cnt   (arb_outst_cnt),
    .arb_err         (arb_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight requester IDs in issue order, current bus owner, preference, error.
  bit            mq[$];
  int            m_owner = -1;
  int            m_pref  = 0;
  bit            m_err   = 1'b0;
  bit            chk_en  = 1'b0;
  int            who;
  bit            ex_sreq;
  bit            rq[2];
  logic [AW-1:0] ad[2];
  logic [1:0]    ex_resp[2];

  always @(negedge clk) begin
    if (chk_en) begin
      rq[0] = m0_imem_req;  rq[1] = m1_imem_req;
      ad[0] = m0_imem_addr; ad[1] = m1_imem_addr;
      if (m_owner >= 0)           who = m_owner;
      else if (rq[0] && rq[1]) begin
`ifdef SCR1_IMEM_ARB_RR_EN
        who = m_pref;
`else
        who = 0;
`endif
      end
      else if (rq[0])             who = 0;
      else if (rq[1])             who = 1;
      else                        who = -1;
      ex_sreq = 1'b0;
      if (who >= 0) ex_sreq = rq[who] && (mq.size() < DEPTH);
      ex_resp[0] = 2'b00;
      ex_resp[1] = 2'b00;
      if (s_imem_resp != 2'b00 && mq.size() > 0) ex_resp[mq[0]] = s_imem_resp;

      chk("s_req", s_imem_req, ex_sreq);
      if (ex_sreq) chk("s_addr", s_imem_addr, ad[who]);
      chk("m0_ack", m0_imem_req_ack, ex_sreq && s_imem_req_ack && who == 0);
      chk("m1_ack", m1_imem_req_ack, ex_sreq && s_imem_req_ack && who == 1);
      chk("m0_resp", m0_imem_resp, ex_resp[0]);
      chk("m1_resp", m1_imem_resp, ex_resp[1]);
      chk("m0_rdata", m0_imem_rdata, s_imem_rdata);
      chk("m1_rdata", m1_imem_rdata, s_imem_rdata);
      chk("outst_cnt", arb_outst_cnt, mq.size());
      chk("arb_err", arb_err, m_err);

      if (!rst_n) begin
        mq.delete();
        m_owner = -1;
        m_pref  = 0;
        m_err   = 1'b0;
      end else begin
        if (s_imem_resp != 2'b00) begin
          if (mq.size() == 0 || s_imem_resp == 2'b11) m_err = 1'b1;
          if (mq.size() > 0) void'(mq.pop_front());
        end
        if (ex_sreq && s_imem_req_ack) begin
          mq.push_back(who == 1);
          m_pref = 1 - who;
          $display("xfer: m%0d addr=%h accepted, %0d in flight", who, ad[who], mq.size());
        end
        if (m_owner >= 0) begin
          if (!rq[m_owner] || s_imem_req_ack) m_owner = -1;
        end else if (ex_sreq && !s_imem_req_ack) begin
          m_owner = who;
        end
      end
    end
  end

  task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic r1,
                       input logic [AW-1:0] a1, input logic ack, input logic [1:0] resp,
                       input logic [DW-1:0] rdata);
    @(posedge clk); #1;
    m0_imem_req = r0; m0_imem_addr = a0;
    m1_imem_req = r1; m1_imem_addr = a1;
    s_imem_req_ack = ack; s_imem_resp = resp; s_imem_rdata = rdata;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 2'b00, '0);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    m0_imem_req = 1'b0; m1_imem_req = 1'b0;
    s_imem_req_ack = 1'b0; s_imem_resp = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int g;

  initial begin
    rst_n = 1'b0;
    m0_imem_req = 1'b0; m0_imem_addr = '0;
    m1_imem_req = 1'b0; m1_imem_addr = '0;
    s_imem_req_ack = 1'b0; s_imem_rdata = '0; s_imem_resp = 2'b00;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst cnt", arb_outst_cnt, 0);
    chk("rst err", arb_err, 0);
    chk("rst s_req", s_imem_req, 0);
    chk("rst m0_resp", m0_imem_resp, 0);

    // Single m0 fetch
    reset_dut();
    drive(1'b1, 32'h200, 1'b0, '0, 1'b1, 2'b00, '0);
    chk("t1 s_req", s_imem_req, 1);
    chk("t1 s_addr", s_imem_addr, 32'h200);
    chk("t1 m0_ack", m0_imem_req_ack, 1);
    chk("t1 cnt0", arb_outst_cnt, 0);
    idle();
    chk("t1 cnt1", arb_outst_cnt, 1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 2'b01, 32'h00C5E533);
    chk("t1 m0_resp", m0_imem_resp, 2'b01);
    chk("t1 m0_rdata", m0_imem_rdata, 32'h00C5E533);
    chk("t1 m1_resp", m1_imem_resp, 2'b00);
    idle();
    chk("t1 cnt end", arb_outst_cnt, 0);

    // Contention with instant ack
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h1000 + 32'(k * 4), 1'b1, 32'h2000 + 32'(k * 4), 1'b1,
            (k == 0) ? 2'b00 : 2'b01, $urandom);
`ifdef SCR1_IMEM_ARB_RR_EN
      g = k % 2;
`else
      g = 0;
`endif
      chk("t2 m0_ack", m0_imem_req_ack, g == 0);
      chk("t2 m1_ack", m1_imem_req_ack, g == 1);
      chk("t2 s_addr", s_imem_addr, (g == 1) ? 32'h2000 + 32'(k * 4) : 32'h1000 + 32'(k * 4));
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 2'b01, '0);
    idle();
    chk("t2 cnt end", arb_outst_cnt, 0);

    // Lock hold on m1 while m0 arrives
    reset_dut();
    drive(1'b0, '0, 1'b1, 32'h8000, 1'b0, 2'b00, '0);
    chk("t3 s_addr c1", s_imem_addr, 32'h8000);
    drive(1'b1, 32'h300, 1'b1, 32'h8000, 1'b0, 2'b00, '0);
    chk("t3 s_addr c2", s_imem_addr, 32'h8000);
    chk("t3 m0_ack c2", m0_imem_req_ack, 0);
    drive(1'b1, 32'h300, 1'b1, 32'h8000, 1'b0, 2'b00, '0);
    chk("t3 s_addr c3", s_imem_addr, 32'h8000);
    drive(1'b1, 32'h300, 1'b1, 32'h8000, 1'b1, 2'b00, '0);
    chk("t3 s_addr c4", s_imem_addr, 32'h8000);
    chk("t3 m1_ack c4", m1_imem_req_ack, 1);
    chk("t3 m0_ack c4", m0_imem_req_ack, 0);
    drive(1'b1, 32'h300, 1'b0, '0, 1'b1, 2'b00, '0);
    chk("t3 s_addr c5", s_imem_addr, 32'h300);
    chk("t3 m0_ack c5", m0_imem_req_ack, 1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 2'b01, 32'h11);
    chk("t3 m1_resp", m1_imem_resp, 2'b01);
    chk("t3 m0_resp0", m0_imem_resp, 2'b00);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 2'b01, 32'h22);
    chk("t3 m0_resp", m0_imem_resp, 2'b01);
    idle();

    // Full stall
    reset_dut();
    drive(1'b1, 32'h400, 1'b0, '0, 1'b1, 2'b00, '0);
    chk("t4 ack1", m0_imem_req_ack, 1);
    drive(1'b1, 32'h404, 1'b0, '0, 1'b1, 2'b00, '0);
    chk("t4 ack2", m0_imem_req_ack, 1);
    drive(1'b1, 32'h408, 1'b0, '0, 1'b1, 2'b00, '0);
    chk("t4 full s_req", s_imem_req, 0);
    chk("t4 full cnt", arb_outst_cnt, 2);
    drive(1'b1, 32'h408, 1'b0, '0, 1'b1, 2'b01, '0);
    chk("t4 pop s_req", s_imem_req, 0);
    chk("t4 pop m0_resp", m0_imem_resp, 2'b01);
    drive(1'b1, 32'h408, 1'b0, '0, 1'b1, 2'b00, '0);
    chk("t4 resume s_req", s_imem_req, 1);
    chk("t4 resume cnt", arb_outst_cnt, 1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 2'b01, '0);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 2'b01, '0);
    idle();
    chk("t4 cnt end", arb_outst_cnt, 0);

    // Response ordering
    reset_dut();
    drive(1'b1, 32'h500, 1'b0, '0, 1'b1, 2'b00, '0);
    drive(1'b0, '0, 1'b1, 32'h600, 1'b1, 2'b00, '0);
    chk("t5 m1_ack", m1_imem_req_ack, 1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 2'b10, 32'hA);
    chk("t5 m0_resp err", m0_imem_resp, 2'b10);
    chk("t5 m1_resp idle", m1_imem_resp, 2'b00);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 2'b01, 32'hB);
    chk("t5 m1_resp ok", m1_imem_resp, 2'b01);
    chk("t5 m0_resp idle", m0_imem_resp, 2'b00);
    idle();
    chk("t5 cnt end", arb_outst_cnt, 0);

    // Error flag and reset
    reset_dut();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 2'b01, '0);
    chk("t6 m0_resp drop", m0_imem_resp, 2'b00);
    chk("t6 m1_resp drop", m1_imem_resp, 2'b00);
    idle();
    chk("t6 err set", arb_err, 1);
    reset_dut();
    chk("t6 err clr", arb_err, 0);
    chk("t6 cnt clr", arb_outst_cnt, 0);
    drive(1'b1, 32'h700, 1'b0, '0, 1'b1, 2'b00, '0);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 2'b11, '0);
    chk("t6 resp11 routed", m0_imem_resp, 2'b11);
    idle();
    chk("t6 err 11", arb_err, 1);
    chk("t6 cnt 11", arb_outst_cnt, 0);

    // Randomized traffic against the model
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      rst_n          = ($urandom_range(0, 249) != 0);
      m0_imem_req    = ($urandom_range(0, 99) < 55);
      m1_imem_req    = ($urandom_range(0, 99) < 55);
      m0_imem_addr   = $urandom & 32'hFFFF_FFFC;
      m1_imem_addr   = $urandom & 32'hFFFF_FFFC;
      s_imem_req_ack = ($urandom_range(0, 99) < 50);
      s_imem_rdata   = $urandom;
      if (mq.size() > 0 && $urandom_range(0, 99) < 45)
        s_imem_resp = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b01;
      else if ($urandom_range(0, 399) == 0)
        s_imem_resp = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
      else
        s_imem_resp = 2'b00;
    end
    reset_dut();
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
